// File: rtl/tcp_vlg_tx_sched.sv
`default_nettype none
//==============================================================================
// Module : tcp_vlg_tx_sched
// Brief  : Transmit scheduler for one TCP connection. It arbitrates five
//          requesters onto the tx engine and watchdogs the start/done handshake.
// Rev    : 1.0 - initial release
//==============================================================================
module tcp_vlg_tx_sched #(
  parameter int STARVE_LIMIT = 8,
  parameter int TX_TIMEOUT   = 1000,
  parameter int VERBOSE      = 0,
  parameter     DUT_STRING   = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       connected,
  input  logic       rtx_req,
  input  logic       ack_req,
  input  logic       dat_req,
  input  logic       fin_req,
  input  logic       ka_req,
  output logic       rtx_sent,
  output logic       ack_sent,
  output logic       dat_sent,
  output logic       fin_sent,
  output logic       ka_sent,
  output logic       tx_strt,
  output logic [2:0] tx_type,
  input  logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0]  c_type_none = 3'd0;
  localparam logic [2:0]  c_type_ack  = 3'd1;
  localparam logic [2:0]  c_type_dat  = 3'd2;
  localparam logic [2:0]  c_type_rtx  = 3'd3;
  localparam logic [2:0]  c_type_fin  = 3'd4;
  localparam logic [2:0]  c_type_ka   = 3'd5;
  localparam logic [7:0]  c_starve_max = 8'(STARVE_LIMIT);
  localparam logic [15:0] c_timeout    = 16'(TX_TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_type;
  logic [2:0]  w_type_nxt;
  logic [7:0]  r_starve;
  logic [7:0]  w_starve_nxt;
  logic [15:0] r_wdog;
  logic [15:0] w_wdog_nxt;
  logic        r_err;
  logic        w_err_nxt;
  logic [2:0]  w_grant;
  logic        w_any_req;
  logic        w_force_dat;
  logic        w_done;
  logic        w_piggy_ack;

  assign w_any_req = rtx_req | ack_req | dat_req | fin_req | ka_req;

  // Fixed priority, overridden when new data has waited out the starvation limit
  always_comb begin
    w_force_dat = (r_starve == c_starve_max) && dat_req;
    w_grant     = c_type_none;
    if (w_force_dat) begin
      w_grant = c_type_dat;
    end else if (rtx_req) begin
      w_grant = c_type_rtx;
    end else if (ack_req) begin
      w_grant = c_type_ack;
    end else if (dat_req) begin
      w_grant = c_type_dat;
    end else if (fin_req && !rtx_req && !dat_req) begin
      w_grant = c_type_fin;
    end else if (ka_req) begin
      w_grant = c_type_ka;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_type_nxt   = r_type;
    w_starve_nxt = r_starve;
    w_wdog_nxt   = r_wdog;
    w_err_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!dat_req) begin
          w_starve_nxt = '0;
        end
        if (connected && w_any_req) begin
          w_type_nxt  = w_grant;
          w_state_nxt = S_START;
          if (w_grant == c_type_dat) begin
            w_starve_nxt = '0;
          end else if ((w_grant == c_type_rtx || w_grant == c_type_ack) && dat_req &&
                       (r_starve != c_starve_max)) begin
            w_starve_nxt = 8'(r_starve + 8'd1);
          end
        end
      end
      S_START: begin
        w_wdog_nxt = '0;
        if (!connected) begin
          w_type_nxt  = c_type_none;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_wdog_nxt = 16'(r_wdog + 16'd1);
        // Losing the connection silently drops the packet; a late tx_done lands in IDLE
        if (!connected) begin
          w_type_nxt  = c_type_none;
          w_state_nxt = S_IDLE;
        end else if (tx_done) begin
          w_state_nxt = S_DONE;
        end else if (r_wdog == c_timeout) begin
          w_err_nxt   = 1'b1;
          w_type_nxt  = c_type_none;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_type_nxt  = c_type_none;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_type_nxt  = c_type_none;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_type   <= c_type_none;
      r_starve <= '0;
      r_wdog   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_type   <= w_type_nxt;
      r_starve <= w_starve_nxt;
      r_wdog   <= w_wdog_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Every segment carries the current Ack number, so these also retire a pure Ack
  assign w_done      = (r_state == S_DONE);
  assign w_piggy_ack = (r_type == c_type_rtx) || (r_type == c_type_dat) || (r_type == c_type_fin);

  assign tx_strt  = (r_state == S_START);
  assign tx_type  = r_type;
  assign tx_err   = r_err;
  assign rtx_sent = w_done && (r_type == c_type_rtx);
  assign ack_sent = w_done && ((r_type == c_type_ack) || w_piggy_ack);
  assign dat_sent = w_done && (r_type == c_type_dat);
  assign fin_sent = w_done && (r_type == c_type_fin);
  assign ka_sent  = w_done && (r_type == c_type_ka);

  generate
    if (VERBOSE != 0 && DUT_STRING != "") begin : g_verbose
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tcp_vlg_tx_sched.sv
`default_nettype none
//==============================================================================
// Module : tb_tcp_vlg_tx_sched
// Brief  : Scoreboard bench for tcp_vlg_tx_sched with directed request patterns.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_tcp_vlg_tx_sched;

  localparam int STARVE_LIMIT = 2;
  localparam int TX_TIMEOUT   = 10;

  localparam logic [2:0] T_ACK = 3'd1;
  localparam logic [2:0] T_DAT = 3'd2;
  localparam logic [2:0] T_RTX = 3'd3;
  localparam logic [2:0] T_FIN = 3'd4;
  localparam logic [2:0] T_KA  = 3'd5;
  // end vector order: rtx_sent, ack_sent, dat_sent, fin_sent, ka_sent, tx_err
  localparam logic [5:0] E_ACK = 6'b010000;
  localparam logic [5:0] E_RTX = 6'b110000;
  localparam logic [5:0] E_DAT = 6'b011000;
  localparam logic [5:0] E_FIN = 6'b010100;
  localparam logic [5:0] E_KA  = 6'b000010;
  localparam logic [5:0] E_ERR = 6'b000001;

  typedef struct packed {
    logic       kind;
    logic [5:0] val;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       connected;
  logic       rtx_req, ack_req, dat_req, fin_req, ka_req;
  logic       rtx_sent, ack_sent, dat_sent, fin_sent, ka_sent;
  logic       tx_strt;
  logic [2:0] tx_type;
  logic       tx_done;
  logic       tx_err;
  logic [5:0] endv;

  ev_t exp_q[$];
  int  strt_t[$];
  int  end_t[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc_cnt = 0;
  int  done_dly = 0;
  int  hang_pkt = -1;
  int  pkt_idx = 0;
  int  n_raise = 0;

  tcp_vlg_tx_sched #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .TX_TIMEOUT  (TX_TIMEOUT),
    .VERBOSE     (0),
    .DUT_STRING  ("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .connected(connected),
    .rtx_req  (rtx_req),
    .ack_req  (ack_req),
    .dat_req  (dat_req),
    .fin_req  (fin_req),
    .ka_req   (ka_req),
    .rtx_sent (rtx_sent),
    .ack_sent (ack_sent),
    .dat_sent (dat_sent),
    .fin_sent (fin_sent),
    .ka_sent  (ka_sent),
    .tx_strt  (tx_strt),
    .tx_type  (tx_type),
    .tx_done  (tx_done),
    .tx_err   (tx_err)
  );

  assign endv = {rtx_sent, ack_sent, dat_sent, fin_sent, ka_sent, tx_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_pop(input logic kind, input logic [5:0] val, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_%s_unexpected: got 0x%0h expected no output", name, val);
    end else begin
      e = exp_q.pop_front();
      chk({"sb_", name}, int'({kind, val}), int'({e.kind, e.val}));
    end
  endtask

  task automatic exp_strt(input logic [2:0] typ);
    exp_q.push_back({1'b0, 3'b000, typ});
  endtask

  task automatic exp_pkt(input logic [2:0] typ, input logic [5:0] ev);
    exp_strt(typ);
    exp_q.push_back({1'b1, ev});
  endtask

  function automatic int st(input int i);
    return (i < strt_t.size()) ? strt_t[i] : -1000;
  endfunction

  function automatic int en(input int i);
    return (i < end_t.size()) ? end_t[i] : -1000;
  endfunction

  // One cycle of requester behaviour: drop a request once its *_sent is seen
  task automatic cyc();
    @(negedge clk);
    #1;
    if (rtx_sent) rtx_req = 1'b0;
    if (ack_sent) ack_req = 1'b0;
    if (dat_sent) dat_req = 1'b0;
    if (fin_sent) fin_req = 1'b0;
    if (ka_sent)  ka_req  = 1'b0;
    if (n_raise > 0 && !ack_req) begin
      ack_req = 1'b1;
      n_raise--;
    end
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (exp_q.size() != 0 && b > 0) begin
      cyc();
      b--;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) cyc();
  endtask

  task automatic wait_strt(input int s0, input int budget);
    int b;
    b = budget;
    while (strt_t.size() <= s0 && b > 0) begin
      cyc();
      b--;
    end
    if (strt_t.size() <= s0) chk("wait_strt_timeout", strt_t.size(), s0 + 1);
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (tx_strt) begin
          strt_t.push_back(cyc_cnt);
          sb_pop(1'b0, {3'b000, tx_type}, "strt");
        end
        if (|endv) begin
          end_t.push_back(cyc_cnt);
          sb_pop(1'b1, endv, "end");
        end
      end
    end
  end

  // Tx engine model: answers tx_strt with tx_done after done_dly extra WAIT cycles
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && tx_strt) begin
        if (pkt_idx != hang_pkt) begin
          pkt_idx++;
          repeat (done_dly + 1) @(negedge clk);
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
        end else begin
          pkt_idx++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t_req;
    int s0;
    int e0;
    rst = 1'b0;
    connected = 1'b0;
    rtx_req = 1'b0; ack_req = 1'b0; dat_req = 1'b0; fin_req = 1'b0; ka_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_tx_strt", int'(tx_strt), 0);
    chk("reset_tx_type", int'(tx_type), 0);
    chk("reset_sent", int'(endv[5:1]), 0);
    chk("reset_tx_err", int'(tx_err), 0);
    rst = 1'b1;
    connected = 1'b1;
    repeat (2) cyc();

    // Single ACK, tx_done on the first WAIT cycle
    done_dly = 0;
    s0 = strt_t.size();
    e0 = end_t.size();
    exp_pkt(T_ACK, E_ACK);
    ack_req = 1'b1;
    t_req = cyc_cnt;
    drain(20);
    chk("ack_strt_latency", st(s0) - t_req, 1);
    chk("ack_sent_latency", en(e0) - t_req, 3);

    // Collision: RTX first (retires the Ack too), then DAT back to back
    s0 = strt_t.size();
    exp_pkt(T_RTX, E_RTX);
    exp_pkt(T_DAT, E_DAT);
    rtx_req = 1'b1; ack_req = 1'b1; dat_req = 1'b1;
    drain(30);
    chk("collision_pkt_spacing", st(s0 + 1) - st(s0), 4);

    // Starvation: two ACK grants while DAT waits, then DAT is forced ahead of ACK
    exp_pkt(T_ACK, E_ACK);
    exp_pkt(T_ACK, E_ACK);
    exp_pkt(T_DAT, E_DAT);
    n_raise = 2;
    ack_req = 1'b1; dat_req = 1'b1;
    drain(40);
    // Counter cleared by the DAT grant: ACK wins again
    exp_pkt(T_ACK, E_ACK);
    exp_pkt(T_DAT, E_DAT);
    ack_req = 1'b1; dat_req = 1'b1;
    drain(30);

    // FIN waits for DAT; KA comes last and carries no piggybacked Ack
    exp_pkt(T_DAT, E_DAT);
    exp_pkt(T_FIN, E_FIN);
    exp_pkt(T_KA, E_KA);
    fin_req = 1'b1; dat_req = 1'b1; ka_req = 1'b1;
    drain(40);

    // Watchdog abort, then the still-pending ACK is retried normally
    s0 = strt_t.size();
    e0 = end_t.size();
    hang_pkt = pkt_idx;
    exp_pkt(T_ACK, E_ERR);
    exp_pkt(T_ACK, E_ACK);
    ack_req = 1'b1;
    drain(60);
    chk("wdog_err_latency", en(e0) - st(s0), TX_TIMEOUT + 2);
    chk("wdog_retry_latency", st(s0 + 1) - en(e0), 1);

    // Disconnect in WAIT: no pulses, late tx_done ignored, no grants while down
    s0 = strt_t.size();
    done_dly = 5;
    exp_strt(T_ACK);
    ack_req = 1'b1;
    wait_strt(s0, 10);
    cyc();
    connected = 1'b0;
    cyc();
    chk("disc_tx_type", int'(tx_type), 0);
    repeat (8) cyc();
    chk("disc_no_pending", exp_q.size(), 0);
    chk("disc_no_grant", strt_t.size(), s0 + 1);
    done_dly = 0;
    exp_pkt(T_ACK, E_ACK);
    connected = 1'b1;
    drain(20);

    // Asynchronous reset in WAIT clears outputs immediately
    s0 = strt_t.size();
    e0 = end_t.size();
    hang_pkt = pkt_idx;
    exp_strt(T_ACK);
    ack_req = 1'b1;
    wait_strt(s0, 10);
    cyc();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_wait_tx_type", int'(tx_type), 0);
    chk("rst_wait_tx_strt", int'(tx_strt), 0);
    chk("rst_wait_sent_err", int'(endv), 0);
    ack_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) cyc();
    chk("rst_release_no_pulse", end_t.size(), e0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
